// File: rtl/uart_rom_loader.sv
// UART (8N1) program loader for the instruction ROM: header N, then N words.
// Ports: CLK_50/reset in; uart_rx in; rom_address/rom_data/rom_we out;
//   cpu_hold, load_done, frame_error, word_count status out.
module uart_rom_loader #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  CLK_50,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic [DATA_WIDTH-1:0] rom_data,
   output logic                  rom_we,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  frame_error,
   output logic [15:0]           word_count
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;
   localparam logic [15:0] BIT_M1  = 16'(BIT_CYCLES - 1);
   localparam logic [15:0] HALF_M1 = 16'(BIT_CYCLES / 2 - 1);
   localparam logic [16:0] DEPTH   = 17'(2 ** ADDR_WIDTH);

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
   } rx_state_t;

   typedef enum logic [2:0] {
      L_HDR_HI, L_HDR_LO, L_DATA_HI, L_DATA_LO,
      L_WRITE, L_DONE, L_ERROR
   } ld_state_t;

   rx_state_t rx_state, rx_next;
   ld_state_t ld_state, ld_next;

   logic        rx_s1, rx_s2, rx_q;
   logic        rx_fall;
   logic [15:0] cnt, cnt_max;
   logic        cnt_done;
   logic [2:0]  bit_idx;
   logic [7:0]  rx_byte;
   logic        byte_valid, frame_err;

   logic [7:0]  hdr_hi, hi_byte;
   logic [15:0] n_words, widx;
   logic        ovf;

   // rx_q only remembers the previous synced sample for edge detection
   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_q  <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
         rx_q  <= rx_s2;
      end
   end

   assign rx_fall  = rx_q & ~rx_s2;
   assign cnt_max  = (rx_state == RX_START) ? HALF_M1 : BIT_M1;
   assign cnt_done = (cnt == cnt_max);

   always_comb begin
      rx_next    = rx_state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      unique case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (cnt_done)
                      rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (cnt_done && bit_idx == 3'd7)
                      rx_next = RX_STOP;
         RX_STOP: begin
            if (cnt_done) begin
               byte_valid = rx_s2;
               frame_err  = ~rx_s2;
               rx_next    = rx_s2 ? RX_IDLE : RX_WAIT;
            end
         end
         RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         rx_byte  <= '0;
      end else begin
         rx_state <= rx_next;
         // counter restarts on every state change and every bit sample
         if (rx_state == RX_IDLE || rx_next != rx_state || cnt_done)
            cnt <= '0;
         else
            cnt <= cnt + 16'd1;
         if (rx_state == RX_START)
            bit_idx <= '0;
         else if (rx_state == RX_DATA && cnt_done) begin
            bit_idx <= bit_idx + 3'd1;
            rx_byte <= {rx_s2, rx_byte[7:1]};
         end
      end
   end

   // words past the ROM depth are consumed but never written
   assign ovf = ({1'b0, widx} >= DEPTH);

   always_comb begin
      ld_next = ld_state;
      if (frame_err)
         ld_next = L_ERROR;
      else begin
         unique case (ld_state)
            L_HDR_HI:  if (byte_valid) ld_next = L_HDR_LO;
            L_HDR_LO:  if (byte_valid)
                          ld_next = ({hdr_hi, rx_byte} == 16'd0)
                                    ? L_DONE : L_DATA_HI;
            L_DATA_HI: if (byte_valid) ld_next = L_DATA_LO;
            L_DATA_LO: if (byte_valid) ld_next = L_WRITE;
            L_WRITE:   ld_next = (widx + 16'd1 == n_words)
                                 ? L_DONE : L_DATA_HI;
            L_DONE:    ld_next = L_DONE;
            L_ERROR:   ld_next = L_ERROR;
            default:   ld_next = L_ERROR;
         endcase
      end
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         ld_state    <= L_HDR_HI;
         hdr_hi      <= '0;
         hi_byte     <= '0;
         n_words     <= '0;
         widx        <= '0;
         word_count  <= '0;
         rom_address <= '0;
         rom_data    <= '0;
         load_done   <= 1'b0;
      end else begin
         ld_state <= ld_next;
         if (byte_valid) begin
            unique case (ld_state)
               L_HDR_HI:  hdr_hi  <= rx_byte;
               L_HDR_LO:  n_words <= {hdr_hi, rx_byte};
               L_DATA_HI: hi_byte <= rx_byte;
               L_DATA_LO: if (!ovf) begin
                  rom_data    <= DATA_WIDTH'({hi_byte, rx_byte});
                  rom_address <= widx[ADDR_WIDTH-1:0];
               end
               default: ;
            endcase
         end
         if (ld_state == L_WRITE) begin
            widx <= widx + 16'd1;
            if (!ovf)
               word_count <= word_count + 16'd1;
         end
         if (ld_next == L_DONE)
            load_done <= 1'b1;
      end
   end

   assign rom_we      = (ld_state == L_WRITE) && !ovf;
   assign cpu_hold    = (ld_state != L_DONE);
   assign frame_error = (ld_state == L_ERROR);

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader at 16 clocks/bit, 4-word ROM.
// Ports: drives CLK_50/reset/uart_rx, watches all outputs.
module tb_uart_rom_loader;

   localparam int BITC = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        uart_rx = 1'b1;
   logic [1:0]  rom_address;
   logic [15:0] rom_data;
   logic        rom_we;
   logic        cpu_hold;
   logic        load_done;
   logic        frame_error;
   logic [15:0] word_count;

   int checks = 0;
   int passed = 0;

   logic [1:0]  wa[$];
   logic [15:0] wd[$];

   uart_rom_loader #(
      .CLK_FREQ(1_600_000),
      .BAUD(100_000),
      .DATA_WIDTH(16),
      .ADDR_WIDTH(2)
   ) dut (
      .CLK_50(clk),
      .reset(reset),
      .uart_rx(uart_rx),
      .rom_address(rom_address),
      .rom_data(rom_data),
      .rom_we(rom_we),
      .cpu_hold(cpu_hold),
      .load_done(load_done),
      .frame_error(frame_error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rom_we === 1'b1) begin
         wa.push_back(rom_address);
         wd.push_back(rom_data);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b,
                            input logic stop_bit);
      uart_rx = 1'b0;
      idle(BITC);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(BITC);
      end
      uart_rx = stop_bit;
      idle(BITC);
      uart_rx = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      uart_rx = 1'b1;
      idle(3);
      reset = 1'b0;
      wa.delete();
      wd.delete();
      idle(4);
   endtask

   task automatic chk_reset_vals(input string tag);
      checks++;
      if ({cpu_hold, load_done, frame_error, rom_we} !== 4'b1000)
         $display("FAIL %s flags act=%b exp=1000", tag,
                  {cpu_hold, load_done, frame_error, rom_we});
      else passed++;
      checks++;
      if ({rom_address, rom_data, word_count} !== 34'd0)
         $display("FAIL %s regs addr=%h data=%h cnt=%0d exp=0",
                  tag, rom_address, rom_data, word_count);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      chk_reset_vals("reset_in");
      reset = 1'b0;
      idle(4);
      chk_reset_vals("reset_out");
   endtask

   task automatic test_load();
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      checks++;
      if (wa.size() !== 1 || load_done !== 1'b0)
         $display("FAIL load_mid writes=%0d done=%b exp=1,0",
                  wa.size(), load_done);
      else passed++;
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      idle(4);
      checks++;
      if (wa.size() !== 2)
         $display("FAIL load_nwr act=%0d exp=2", wa.size());
      else passed++;
      if (wa.size() == 2) begin
         checks++;
         if (wa[0] !== 2'd0 || wd[0] !== 16'h1234)
            $display("FAIL load_w0 act=%0d/%h exp=0/1234",
                     wa[0], wd[0]);
         else passed++;
         checks++;
         if (wa[1] !== 2'd1 || wd[1] !== 16'hABCD)
            $display("FAIL load_w1 act=%0d/%h exp=1/abcd",
                     wa[1], wd[1]);
         else passed++;
      end
      checks++;
      if ({load_done, cpu_hold} !== 2'b10 || word_count !== 16'd2)
         $display("FAIL load_end done=%b hold=%b cnt=%0d exp=1,0,2",
                  load_done, cpu_hold, word_count);
      else passed++;
   endtask

   task automatic test_empty();
      do_reset();
      send_byte(8'h00, 1'b1);
      checks++;
      if (load_done !== 1'b0 || cpu_hold !== 1'b1)
         $display("FAIL empty_mid done=%b hold=%b exp=0,1",
                  load_done, cpu_hold);
      else passed++;
      send_byte(8'h00, 1'b1);
      checks++;
      if ({load_done, cpu_hold} !== 2'b10 || wa.size() !== 0)
         $display("FAIL empty_end done=%b hold=%b wr=%0d exp=1,0,0",
                  load_done, cpu_hold, wa.size());
      else passed++;
   endtask

   task automatic test_framing();
      do_reset();
      send_byte(8'h00, 1'b0);
      idle(BITC);
      checks++;
      if ({frame_error, cpu_hold} !== 2'b11)
         $display("FAIL frame_flag err=%b hold=%b exp=1,1",
                  frame_error, cpu_hold);
      else passed++;
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(4);
      checks++;
      if (wa.size() !== 0 || load_done !== 1'b0 ||
          frame_error !== 1'b1 || cpu_hold !== 1'b1)
         $display("FAIL frame_after wr=%0d done=%b err=%b hold=%b exp=0,0,1,1",
                  wa.size(), load_done, frame_error, cpu_hold);
      else passed++;
   endtask

   task automatic test_glitch();
      do_reset();
      uart_rx = 1'b0;
      idle(5);
      uart_rx = 1'b1;
      idle(3 * BITC);
      send_byte(8'h00, 1'b1);
      checks++;
      if (load_done !== 1'b0)
         $display("FAIL glitch_mid done=%b exp=0", load_done);
      else passed++;
      send_byte(8'h00, 1'b1);
      idle(4);
      checks++;
      if ({load_done, cpu_hold, frame_error} !== 3'b100 ||
          wa.size() !== 0)
         $display("FAIL glitch_end done=%b hold=%b err=%b wr=%0d exp=1,0,0,0",
                  load_done, cpu_hold, frame_error, wa.size());
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      idle(2);
      checks++;
      if (word_count !== 16'd1 || rom_data !== 16'h1234)
         $display("FAIL rmid_pre cnt=%0d data=%h exp=1,1234",
                  word_count, rom_data);
      else passed++;
      reset = 1'b1;
      idle(2);
      chk_reset_vals("rmid_rst");
      reset = 1'b0;
      wa.delete();
      wd.delete();
      idle(4);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hEF, 1'b1);
      idle(4);
      checks++;
      if (wa.size() !== 1)
         $display("FAIL rmid_nwr act=%0d exp=1", wa.size());
      else passed++;
      if (wa.size() == 1) begin
         checks++;
         if (wa[0] !== 2'd0 || wd[0] !== 16'hBEEF)
            $display("FAIL rmid_w0 act=%0d/%h exp=0/beef",
                     wa[0], wd[0]);
         else passed++;
      end
      checks++;
      if ({load_done, cpu_hold} !== 2'b10 || word_count !== 16'd1)
         $display("FAIL rmid_end done=%b hold=%b cnt=%0d exp=1,0,1",
                  load_done, cpu_hold, word_count);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [15:0] w;
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h05, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         w = 16'(i) * 16'h1111;
         send_byte(w[15:8], 1'b1);
         if (i == 5) begin
            checks++;
            if (load_done !== 1'b0)
               $display("FAIL ovf_early done=%b exp=0", load_done);
            else passed++;
         end
         send_byte(w[7:0], 1'b1);
      end
      idle(4);
      checks++;
      if (wa.size() !== 4)
         $display("FAIL ovf_nwr act=%0d exp=4", wa.size());
      else passed++;
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         w = 16'(i + 1) * 16'h1111;
         checks++;
         if (wa[i] !== 2'(i) || wd[i] !== w)
            $display("FAIL ovf_w%0d act=%0d/%h exp=%0d/%h",
                     i, wa[i], wd[i], i, w);
         else passed++;
      end
      checks++;
      if (load_done !== 1'b1 || word_count !== 16'd4 ||
          rom_address !== 2'd3 || rom_data !== 16'h4444)
         $display("FAIL ovf_end done=%b cnt=%0d addr=%0d data=%h exp=1,4,3,4444",
                  load_done, word_count, rom_address, rom_data);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_load();
      test_empty();
      test_framing();
      test_glitch();
      test_reset_mid();
      test_overflow();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
